// File: rtl/ycbcr2rgb_pipe.sv
// ycbcr2rgb_pipe
//   Three-stage pipelined YCbCr -> RGB converter with valid/ready flow control.
//   The conversion matrix is chosen per pixel and travels with the pixel, so a
//   mode change between consecutive pixels needs no flush.
//     stage 1 : clamp (studio modes) and offset removal
//     stage 2 : five signed coefficient products
//     stage 3 : sum, round half up, saturate, register onto out_*
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high; drops every in-flight pixel
//   mode       matrix select: 0 BT.601 studio, 1 BT.601 full, 2 BT.709 studio,
//              3 treated as 0
//   in_valid   input pixel present
//   in_ready   pipeline can take a pixel this cycle
//   in_y/cb/cr unsigned IN_W-bit components
//   in_tag     sideband (syncs, blank), delayed with the pixel
//   out_valid  output pixel present
//   out_ready  downstream accepts this cycle
//   out_r/g/b  unsigned OUT_W-bit RGB, registered
//   out_tag    sideband of the output pixel
module ycbcr2rgb_pipe #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_y,
  input  logic [IN_W-1:0]  in_cb,
  input  logic [IN_W-1:0]  in_cr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_r,
  output logic [OUT_W-1:0] out_g,
  output logic [OUT_W-1:0] out_b,
  output logic [TAG_W-1:0] out_tag
);

  localparam int DW = IN_W + 2;           // offset-removed components
  localparam int PW = IN_W + 16;          // 14-bit coeff x DW-bit operand
  localparam int AW = IN_W + 18;          // three-term accumulator
  localparam int SH = 11 + IN_W - OUT_W;  // coefficient scale plus width change

  localparam logic [IN_W-1:0] K16   = IN_W'(16 << (IN_W - 8));
  localparam logic [IN_W-1:0] K128  = IN_W'(128 << (IN_W - 8));
  localparam logic [IN_W-1:0] Y_HI  = IN_W'(235 << (IN_W - 8));
  localparam logic [IN_W-1:0] C_HI  = IN_W'(240 << (IN_W - 8));

  localparam logic signed [AW-1:0] HALF = AW'(1) << (SH - 1);
  localparam logic signed [AW-1:0] MAXV = AW'((1 << OUT_W) - 1);

  logic en;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  function automatic logic [IN_W-1:0] clamp(input logic [IN_W-1:0] v,
                                            input logic [IN_W-1:0] lo,
                                            input logic [IN_W-1:0] hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

  function automatic logic [OUT_W-1:0] sat(input logic signed [AW-1:0] v);
    if (v[AW-1])      return '0;
    else if (v > MAXV) return '1;
    else               return v[OUT_W-1:0];
  endfunction

  // ---------------- stage 1 : clamp / offset ----------------
  logic [1:0]             mode_n;
  logic                   studio;
  logic [IN_W-1:0]        y_c, cb_c, cr_c, y_off;
  logic signed [DW-1:0]   yd_n, cbd_n, crd_n;

  always_comb begin
    mode_n = (mode == 2'd3) ? 2'd0 : mode;
    studio = (mode_n != 2'd1);
    y_c    = studio ? clamp(in_y,  K16, Y_HI) : in_y;
    cb_c   = studio ? clamp(in_cb, K16, C_HI) : in_cb;
    cr_c   = studio ? clamp(in_cr, K16, C_HI) : in_cr;
    y_off  = studio ? K16 : '0;
    yd_n   = $signed({2'b00, y_c})  - $signed({2'b00, y_off});
    cbd_n  = $signed({2'b00, cb_c}) - $signed({2'b00, K128});
    crd_n  = $signed({2'b00, cr_c}) - $signed({2'b00, K128});
  end

  logic                   s1_valid;
  logic [1:0]             s1_mode;
  logic [TAG_W-1:0]       s1_tag;
  logic signed [DW-1:0]   s1_yd, s1_cbd, s1_crd;

  // ---------------- stage 2 : products ----------------
  logic signed [13:0]     ky, krcr, kgcr, kgcb, kbcb;
  logic signed [PW-1:0]   py_n, prcr_n, pgcr_n, pgcb_n, pbcb_n;

  always_comb begin
    case (s1_mode)
      2'd1: begin
        ky = 14'sd2048; krcr = 14'sd2871; kgcr = 14'sd1462;
        kgcb = 14'sd705; kbcb = 14'sd3629;
      end
      2'd2: begin
        ky = 14'sd2383; krcr = 14'sd3672; kgcr = 14'sd1092;
        kgcb = 14'sd436; kbcb = 14'sd4325;
      end
      default: begin
        ky = 14'sd2383; krcr = 14'sd3269; kgcr = 14'sd1665;
        kgcb = 14'sd803; kbcb = 14'sd4131;
      end
    endcase
    py_n   = PW'(ky)   * PW'(s1_yd);
    prcr_n = PW'(krcr) * PW'(s1_crd);
    pgcr_n = PW'(kgcr) * PW'(s1_crd);
    pgcb_n = PW'(kgcb) * PW'(s1_cbd);
    pbcb_n = PW'(kbcb) * PW'(s1_cbd);
  end

  logic                   s2_valid;
  logic [TAG_W-1:0]       s2_tag;
  logic signed [PW-1:0]   s2_py, s2_prcr, s2_pgcr, s2_pgcb, s2_pbcb;

  // ---------------- stage 3 : sum / round / saturate ----------------
  logic signed [AW-1:0]   sum_r, sum_g, sum_b;
  logic signed [AW-1:0]   rnd_r, rnd_g, rnd_b;

  always_comb begin
    sum_r = AW'(s2_py) + AW'(s2_prcr);
    sum_g = AW'(s2_py) - AW'(s2_pgcr) - AW'(s2_pgcb);
    sum_b = AW'(s2_py) + AW'(s2_pbcb);
    rnd_r = (sum_r + HALF) >>> SH;
    rnd_g = (sum_g + HALF) >>> SH;
    rnd_b = (sum_b + HALF) >>> SH;
  end

  // Every stage moves on the single global enable; bubbles are allowed.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_mode   <= '0;
      s1_tag    <= '0;
      s1_yd     <= '0;
      s1_cbd    <= '0;
      s1_crd    <= '0;
      s2_valid  <= 1'b0;
      s2_tag    <= '0;
      s2_py     <= '0;
      s2_prcr   <= '0;
      s2_pgcr   <= '0;
      s2_pgcb   <= '0;
      s2_pbcb   <= '0;
      out_valid <= 1'b0;
      out_r     <= '0;
      out_g     <= '0;
      out_b     <= '0;
      out_tag   <= '0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s1_mode   <= mode_n;
      s1_tag    <= in_tag;
      s1_yd     <= yd_n;
      s1_cbd    <= cbd_n;
      s1_crd    <= crd_n;
      s2_valid  <= s1_valid;
      s2_tag    <= s1_tag;
      s2_py     <= py_n;
      s2_prcr   <= prcr_n;
      s2_pgcr   <= pgcr_n;
      s2_pgcb   <= pgcb_n;
      s2_pbcb   <= pbcb_n;
      out_valid <= s2_valid;
      out_r     <= sat(rnd_r);
      out_g     <= sat(rnd_g);
      out_b     <= sat(rnd_b);
      out_tag   <= s2_tag;
    end
  end

endmodule

// File: tb/tb_ycbcr2rgb_pipe.sv
module tb_ycbcr2rgb_pipe;

  localparam int IN_W  = 8;
  localparam int OUT_W = 8;
  localparam int TAG_W = 3;
  localparam int SH    = 11 + IN_W - OUT_W;
  localparam int SCL   = 1 << (IN_W - 8);

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       mode;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_y, in_cb, in_cr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_r, out_g, out_b;
  logic [TAG_W-1:0] out_tag;

  ycbcr2rgb_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_y(in_y), .in_cb(in_cb), .in_cr(in_cr), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_g(out_g), .out_b(out_b), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  bit sb_en        = 1'b1;

  typedef struct {int r; int g; int b; int tag;} exp_t;
  exp_t sbq[$];

  // ---------------- reference model ----------------
  function automatic int round_shift(input int sum);
    int d, n, q;
    d = 1 << SH;
    n = sum + d / 2;
    q = n / d;
    if ((n % d) != 0 && n < 0) q = q - 1;  // floor for negative values
    return q;
  endfunction

  function automatic int saturate(input int v);
    int mx;
    mx = (1 << OUT_W) - 1;
    if (v < 0) return 0;
    if (v > mx) return mx;
    return v;
  endfunction

  function automatic int lim(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic exp_t model(input int m, input int y, input int cb,
                                 input int cr, input int tag);
    exp_t e;
    int yd, cbd, crd, ky, krcr, kgcr, kgcb, kbcb;
    if (m == 1) begin
      yd = y; cbd = cb - 128*SCL; crd = cr - 128*SCL;
      ky = 2048; krcr = 2871; kgcr = 1462; kgcb = 705; kbcb = 3629;
    end else begin
      yd  = lim(y,  16*SCL, 235*SCL) - 16*SCL;
      cbd = lim(cb, 16*SCL, 240*SCL) - 128*SCL;
      crd = lim(cr, 16*SCL, 240*SCL) - 128*SCL;
      if (m == 2) begin
        ky = 2383; krcr = 3672; kgcr = 1092; kgcb = 436; kbcb = 4325;
      end else begin
        ky = 2383; krcr = 3269; kgcr = 1665; kgcb = 803; kbcb = 4131;
      end
    end
    e.r   = saturate(round_shift(ky*yd + krcr*crd));
    e.g   = saturate(round_shift(ky*yd - kgcr*crd - kgcb*cbd));
    e.b   = saturate(round_shift(ky*yd + kbcb*cbd));
    e.tag = tag;
    return e;
  endfunction

  // ---------------- cycle helpers ----------------
  task automatic drive(input bit iv, input int y, input int cb, input int cr,
                       input int m, input int tag, input bit ordy, input bit rst);
    @(negedge clk);
    reset     = rst;
    in_valid  = iv;
    in_y      = IN_W'(y);
    in_cb     = IN_W'(cb);
    in_cr     = IN_W'(cr);
    mode      = 2'(m);
    in_tag    = TAG_W'(tag);
    out_ready = ordy;
  endtask

  // Samples just before the next rising edge: what is seen here is what the
  // edge will transfer.
  task automatic settle(output bit acc);
    exp_t e;
    #1;
    acc = in_valid && in_ready && !reset;
    if (!reset && sb_en) begin
      if (acc) sbq.push_back(model(int'(mode), int'(in_y), int'(in_cb),
                                   int'(in_cr), int'(in_tag)));
      if (out_valid && out_ready) begin
        tests_run++;
        if (sbq.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_pixel: got r=%0d g=%0d b=%0d tag=%0d, expected no pixel",
                   out_r, out_g, out_b, out_tag);
        end else begin
          e = sbq.pop_front();
          if (int'(out_r) !== e.r || int'(out_g) !== e.g ||
              int'(out_b) !== e.b || int'(out_tag) !== e.tag) begin
            tests_failed++;
            $display("FAIL pixel: got r=%0d g=%0d b=%0d tag=%0d, expected r=%0d g=%0d b=%0d tag=%0d",
                     out_r, out_g, out_b, out_tag, e.r, e.g, e.b, e.tag);
          end
        end
      end
    end
  endtask

  task automatic step(input bit iv, input int y, input int cb, input int cr,
                      input int m, input int tag, input bit ordy, input bit rst);
    bit acc;
    drive(iv, y, cb, cr, m, tag, ordy, rst);
    settle(acc);
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 0, 0, 0, 0, 0, ordy, 1'b0);
  endtask

  task automatic rnd_step(input bit iv, input int m, input bit ordy);
    step(iv, $urandom_range(0, (1 << IN_W) - 1), $urandom_range(0, (1 << IN_W) - 1),
         $urandom_range(0, (1 << IN_W) - 1), m, $urandom_range(0, (1 << TAG_W) - 1),
         ordy, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 0, 0, 0, 1'b1, 1'b1);
    tests_run++;
    if (out_valid !== 1'b0 || out_r !== '0 || out_g !== '0 || out_b !== '0 || out_tag !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got valid=%0d r=%0d g=%0d b=%0d tag=%0d, expected all 0",
               out_valid, out_r, out_g, out_b, out_tag);
    end
    idle(1'b1);
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %0d, expected 1", in_ready);
    end
  endtask

  task automatic test_directed;
    int dy[6]  = '{235, 16, 81, 81, 0, 5};
    int dcb[6] = '{128, 128, 90, 90, 0, 128};
    int dcr[6] = '{128, 128, 240, 240, 255, 128};
    int dm[6]  = '{0, 0, 0, 3, 1, 0};
    int er[6]  = '{255, 0, 254, 254, 178, 0};
    int eg[6]  = '{255, 0, 0, 0, 0, 0};
    int eb[6]  = '{255, 0, 0, 0, 0, 0};
    sb_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, dy[i], dcb[i], dcr[i], dm[i], 5, 1'b1, 1'b0);
      for (int k = 1; k <= 3; k++) begin
        idle(1'b1);
        tests_run++;
        if (out_valid !== (k == 3)) begin
          tests_failed++;
          $display("FAIL latency[%0d] cycle %0d: got out_valid=%0d, expected %0d",
                   i, k, out_valid, (k == 3));
        end
      end
      tests_run++;
      if (int'(out_r) !== er[i] || int'(out_g) !== eg[i] || int'(out_b) !== eb[i] ||
          out_tag !== 3'b101) begin
        tests_failed++;
        $display("FAIL directed[%0d]: got r=%0d g=%0d b=%0d tag=%0d, expected r=%0d g=%0d b=%0d tag=5",
                 i, out_r, out_g, out_b, out_tag, er[i], eg[i], eb[i]);
      end
    end
    sb_en = 1'b1;
  endtask

  task automatic test_back_to_back;
    for (int s = 0; s < 20; s++) begin
      if (s < 16) rnd_step(1'b1, s % 2, 1'b1);
      else        idle(1'b1);
      if (s >= 3 && s <= 18) begin
        tests_run++;
        if (out_valid !== 1'b1) begin
          tests_failed++;
          $display("FAIL stream_gap step %0d: got out_valid=%0d, expected 1", s, out_valid);
        end
      end
    end
    tests_run++;
    if (sbq.size() != 0) begin
      tests_failed++;
      $display("FAIL stream_drain: got %0d pending, expected 0", sbq.size());
    end
  endtask

  task automatic test_backpressure;
    int sent = 0, stalls = 0;
    bit acc, stalling;
    logic [3*OUT_W+TAG_W:0] held;
    for (int s = 0; s < 60 && !(sent == 4 && sbq.size() == 0); s++) begin
      drive(sent < 4, $urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 255), $urandom_range(0, 3), $urandom_range(0, 7),
            1'b1, 1'b0);
      stalling = out_valid && stalls < 5;
      if (stalling) out_ready = 1'b0;
      settle(acc);
      if (acc) sent++;
      if (stalling) begin
        tests_run++;
        if (stalls == 0) held = {out_valid, out_r, out_g, out_b, out_tag};
        if (in_ready !== 1'b0 || {out_valid, out_r, out_g, out_b, out_tag} !== held) begin
          tests_failed++;
          $display("FAIL stall_hold cycle %0d: got in_ready=%0d outs=%h, expected in_ready=0 outs=%h",
                   stalls, in_ready, {out_valid, out_r, out_g, out_b, out_tag}, held);
        end
        stalls++;
      end
    end
    tests_run++;
    if (stalls != 5 || sent != 4 || sbq.size() != 0) begin
      tests_failed++;
      $display("FAIL backpressure_done: got stalls=%0d sent=%0d pending=%0d, expected 5 4 0",
               stalls, sent, sbq.size());
    end
  endtask

  task automatic test_reset_midstream;
    for (int i = 0; i < 3; i++) rnd_step(1'b1, i, 1'b0);
    step(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
    sbq.delete();
    idle(1'b0);
    tests_run++;
    if (out_valid !== 1'b0 || out_r !== '0 || out_g !== '0 || out_b !== '0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL midstream_reset: got valid=%0d r=%0d g=%0d b=%0d in_ready=%0d, expected 0 0 0 0 1",
               out_valid, out_r, out_g, out_b, in_ready);
    end
    step(1'b1, 200, 60, 180, 2, 6, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      idle(1'b1);
      tests_run++;
      if (out_valid !== (k == 3)) begin
        tests_failed++;
        $display("FAIL post_reset cycle %0d: got out_valid=%0d, expected %0d",
                 k, out_valid, (k == 3));
      end
    end
  endtask

  task automatic test_random;
    for (int s = 0; s < 400; s++)
      rnd_step($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3) != 0);
    for (int s = 0; s < 20 && sbq.size() != 0; s++) idle(1'b1);
    tests_run++;
    if (sbq.size() != 0) begin
      tests_failed++;
      $display("FAIL random_drain: got %0d pending, expected 0", sbq.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; mode = '0; in_valid = 1'b0; in_y = '0; in_cb = '0; in_cr = '0;
    in_tag = '0; out_ready = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
